// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams words into IMEM from address 0, then releases the core.
// Optional trailing XOR checksum word when IMEM_LOADER_CSUM_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no load in progress, core held (after reset or failed checksum)
// ST_LOAD  | accepting payload words, one IMEM write per handshake
// ST_CHECK | accepting the single checksum word (IMEM_LOADER_CSUM_EN only)
// ST_RUN   | load complete, core released; a new start reloads
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_RUN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;
`endif

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_run_q, core_run_d;
    logic              done_q, done_d;
    logic              arm_q, arm_d;
    logic              hs;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]       acc_q, acc_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_run_q <= 1'b0;
            done_q     <= 1'b0;
            arm_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_run_q <= core_run_d;
            done_q     <= done_d;
            arm_q      <= arm_d;
`ifdef IMEM_LOADER_CSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        arm_d   = 1'b0;
        cnt_inc = cnt_q + ONE;
        hs      = s_valid && s_ready;
`ifdef IMEM_LOADER_CSUM_EN
        acc_d   = acc_q;
`endif

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    if (len > CAP) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        cnt_d = '0;
                        len_d = len;
                        if (len == '0) begin
                            state_d = ST_RUN;
                            arm_d   = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
`ifdef IMEM_LOADER_CSUM_EN
                            acc_d   = '0;
`endif
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (start) err_d = 1'b1;
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = {{(29 - ADDR_W){1'b0}}, cnt_q, 2'b00};
                    wdata_d = s_data;
                    cnt_d   = cnt_inc;
`ifdef IMEM_LOADER_CSUM_EN
                    acc_d   = acc_q ^ s_data;
                    if (cnt_inc == len_q) state_d = ST_CHECK;
`else
                    if (cnt_inc == len_q) begin
                        state_d = ST_RUN;
                        arm_d   = 1'b1;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CHECK: begin
                if (start) err_d = 1'b1;
                if (hs) begin
                    if (s_data == acc_q) begin
                        state_d = ST_RUN;
                        arm_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Release one cycle after entering RUN so the final IMEM write has already landed.
        core_run_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        done_d     = arm_q && (state_q == ST_RUN) && (state_d == ST_RUN);
    end

`ifdef IMEM_LOADER_CSUM_EN
    assign busy    = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
    assign busy    = (state_q == ST_LOAD);
`endif
    assign s_ready  = busy;
    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign core_run = core_run_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads against a timeline model.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int LW     = ADDR_W + 1;
    localparam int CAP    = 1 << ADDR_W;

    logic            clk = 1'b0;
    logic            rst_n, start, s_valid;
    logic [LW-1:0]   len;
    logic [31:0]     s_data;
    logic            s_ready, im_we, core_run, busy, done, err;
    logic [31:0]     im_addr, im_wdata;
    logic [LW-1:0]   word_cnt;

    int              n_chk  = 0;
    int              n_fail = 0;
    logic            exp_err;
    logic [31:0]     pay [0:CAP-1];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_run(core_run), .busy(busy), .done(done), .err(err),
        .word_cnt(word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_s_ready"},  s_ready,  0);
        chk({pfx, "_im_we"},    im_we,    0);
        chk({pfx, "_im_addr"},  im_addr,  0);
        chk({pfx, "_im_wdata"}, im_wdata, 0);
        chk({pfx, "_core_run"}, core_run, 0);
        chk({pfx, "_busy"},     busy,     0);
        chk({pfx, "_done"},     done,     0);
        chk({pfx, "_err"},      err,      0);
        chk({pfx, "_word_cnt"}, word_cnt, 0);
    endtask

    // One complete load of pay[0..n-1]. mode: 0 valid held, 1 valid toggling, 2 random valid.
    // csum_flip != 0 corrupts the checksum word (checksum build only).
    task automatic run_load(input int n, input int mode, input bit inject, input logic [31:0] csum_flip);
        logic [31:0] acc;
        int          i, cyc, inj_cyc;
        bit          v;
        acc = '0;
        for (int k = 0; k < n; k++) acc ^= pay[k];
        inj_cyc = $urandom_range(n - 1, 0);

        start = 1'b1; len = LW'(n); s_valid = 1'b0;
        tick();
        start = 1'b0; exp_err = 1'b0;
        chk("ld_core_run_drop", core_run, 0);
        chk("ld_busy", busy, 1);
        chk("ld_cnt_clear", word_cnt, 0);
        chk("ld_err_clear", err, 0);

        i = 0; cyc = 0;
        while (i < n && cyc < 40 * n + 40) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(1, 0));
            endcase
            s_valid = v;
            s_data  = v ? pay[i] : $urandom;
            if (inject && cyc == inj_cyc) begin
                start = 1'b1;
                len   = LW'($urandom);
            end
            chk("ld_ready", s_ready, 1);
            tick();
            start = 1'b0;
            if (inject && cyc == inj_cyc) exp_err = 1'b1;
            chk("wr_we", im_we, {31'b0, v});
            if (v) begin
                chk("wr_addr", im_addr, 32'(i * 4));
                chk("wr_data", im_wdata, pay[i]);
                chk("wr_cnt", word_cnt, 32'(i + 1));
                i++;
            end
            chk("ld_err", err, {31'b0, exp_err});
            cyc++;
        end
        chk("ld_all_words", 32'(i), 32'(n));

        s_valid = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
        chk("ck_ready", s_ready, 1);
        chk("ck_busy", busy, 1);
        chk("ck_done_early", done, 0);
        chk("ck_run_early", core_run, 0);
        s_data = acc ^ csum_flip;
        tick();
        s_data = $urandom;
        chk("ck_no_we", im_we, 0);
        chk("ck_ready_off", s_ready, 0);
        chk("ck_done_wait", done, 0);
        chk("ck_run_wait", core_run, 0);
        if (csum_flip != 0) begin
            exp_err = 1'b1;
            for (int k = 0; k < 3; k++) begin
                chk("bad_err", err, 1);
                chk("bad_busy", busy, 0);
                chk("bad_run", core_run, 0);
                chk("bad_done", done, 0);
                chk("bad_we", im_we, 0);
                tick();
            end
        end else begin
            tick();
            chk("rn_done", done, 1);
            chk("rn_core_run", core_run, 1);
            tick();
            chk("rn_done_pulse", done, 0);
            chk("rn_core_run_hold", core_run, 1);
            chk("rn_err", err, {31'b0, exp_err});
        end
`else
        chk("wr_cycle_ready", s_ready, 0);
        chk("wr_cycle_busy", busy, 0);
        chk("wr_cycle_done", done, 0);
        chk("wr_cycle_run", core_run, 0);
        s_data = $urandom;
        tick();
        chk("rn_done", done, 1);
        chk("rn_core_run", core_run, 1);
        chk("rn_no_we", im_we, 0);
        chk("rn_cnt", word_cnt, 32'(n));
        tick();
        chk("rn_done_pulse", done, 0);
        chk("rn_core_run_hold", core_run, 1);
        chk("rn_err", err, {31'b0, exp_err});
        if (csum_flip != 0) chk("csum_flip_unused", 32'(n), 32'(n));
`endif
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0; exp_err = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // Oversize length: rejected, sticky error, nothing consumed.
        start = 1'b1; len = LW'(CAP + 1); s_valid = 1'b1; s_data = 32'hdead_beef;
        tick();
        start = 1'b0;
        chk("ovf_err", err, 1);
        chk("ovf_ready", s_ready, 0);
        chk("ovf_busy", busy, 0);
        tick();
        chk("ovf_err_sticky", err, 1);
        chk("ovf_no_we", im_we, 0);
        s_valid = 1'b0;

        // Zero length: straight to run with a done pulse, no writes.
        start = 1'b1; len = '0;
        tick();
        start = 1'b0;
        chk("zl_err_clear", err, 0);
        chk("zl_no_we", im_we, 0);
        tick();
        chk("zl_done", done, 1);
        chk("zl_core_run", core_run, 1);
        chk("zl_no_we2", im_we, 0);
        tick();
        chk("zl_done_pulse", done, 0);

        pay[0] = 32'h2008_0005; pay[1] = 32'h2009_0007; pay[2] = 32'h0109_5020;
        run_load(3, 0, 1'b0, 32'h0);
        run_load(3, 1, 1'b0, 32'h0);

        // Words offered while running are not consumed.
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = $urandom;
            chk("run_ready", s_ready, 0);
            tick();
            chk("run_no_we", im_we, 0);
            chk("run_cnt", word_cnt, 3);
        end
        s_valid = 1'b0;

`ifdef IMEM_LOADER_CSUM_EN
        pay[0] = 32'h1; pay[1] = 32'h2;
        run_load(2, 0, 1'b0, 32'h0);
        run_load(2, 0, 1'b0, 32'h7);
`endif

        // Asynchronous reset in the middle of a 4-word load.
        for (int k = 0; k < 4; k++) pay[k] = $urandom;
        start = 1'b1; len = LW'(4);
        tick();
        start = 1'b0; s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data = pay[k];
            tick();
        end
        chk("mid_we_before_rst", im_we, 1);
        rst_n = 1'b0;
        #1;
        s_valid = 1'b0;
        chk_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        pay[0] = $urandom;
        run_load(1, 0, 1'b0, 32'h0);

        // Reload from RUN with a single word.
        pay[0] = $urandom;
        run_load(1, 2, 1'b0, 32'h0);

        for (int r = 0; r < 8; r++) begin
            int          n;
            logic [31:0] flip;
            n = $urandom_range(CAP, 1);
            for (int k = 0; k < n; k++) pay[k] = $urandom;
            flip = ($urandom_range(1, 0) == 1) ? ($urandom | 32'h1) : 32'h0;
            run_load(n, $urandom_range(2, 0), 1'($urandom_range(1, 0)), flip);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
